// File: rtl/axis_tx_arbiter_pkg.sv
// Shared types and widths for the AXI-Stream transmit arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axis_arb_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_STRB_W = 4;
    localparam int AXIS_USER_W = 2;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } arb_state_t;

    // One AXI-Stream beat as carried through the output register.
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic [AXIS_STRB_W-1:0] strb;
        logic [AXIS_STRB_W-1:0] keep;
        logic [AXIS_USER_W-1:0] user;
        logic                   last;
    } axis_beat_t;

endpackage

// File: rtl/axis_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching upward from last+1, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is registered.
//
// Ports:
//   req     - request vector, bit i = source i
//   last    - index of the previously granted source
//   gnt_idx - chosen source (valid only when gnt_vld)
//   gnt_vld - at least one request was present
module rr_pick #(
    parameter int NUM_SRC = 3,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    // One extra bit so last+k cannot overflow before the modulo fold.
    logic [IDX_W:0] cand;

    // Walk from the farthest candidate (last+NUM_SRC, i.e. last itself) toward
    // the nearest (last+1), so the nearest requester is the final assignment.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = {1'b0, last} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_SRC)) begin
                cand = cand - (IDX_W+1)'(NUM_SRC);
            end
            if (req[cand[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream master among NUM_SRC sources.
// Latency: 1 cycle source->master; one idle arbitration cycle between packets.
// Backpressure: s_tready of the granted source = output register empty or draining; others 0.
//
// Ports:
//   axi_aclk / axi_reset          - clock, synchronous active-high reset
//   src_en                        - per-source arbitration enable mask
//   s_t*                          - packed source streams, slice i = source i
//   m_axis_t*                     - registered master stream
//   busy                          - packet in progress
//   cur_grant                     - granted / last-granted source index
//   pkt_cnt                       - completed packets on master (wrapping)
module axis_tx_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int CNT_W   = 16
) (
    input  logic                             axi_aclk,
    input  logic                             axi_reset,
    input  logic [NUM_SRC-1:0]               src_en,
    input  logic [NUM_SRC-1:0]               s_tvalid,
    input  logic [NUM_SRC*AXIS_DATA_W-1:0]   s_tdata,
    input  logic [NUM_SRC*AXIS_STRB_W-1:0]   s_tstrb,
    input  logic [NUM_SRC*AXIS_STRB_W-1:0]   s_tkeep,
    input  logic [NUM_SRC*AXIS_USER_W-1:0]   s_tuser,
    input  logic [NUM_SRC-1:0]               s_tlast,
    output logic [NUM_SRC-1:0]               s_tready,
    output logic                             m_axis_tvalid,
    output logic [AXIS_DATA_W-1:0]           m_axis_tdata,
    output logic [AXIS_STRB_W-1:0]           m_axis_tstrb,
    output logic [AXIS_STRB_W-1:0]           m_axis_tkeep,
    output logic [AXIS_USER_W-1:0]           m_axis_tuser,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic                             busy,
    output logic [$clog2(NUM_SRC)-1:0]       cur_grant,
    output logic [CNT_W-1:0]                 pkt_cnt
);

    localparam int IDX_W = $clog2(NUM_SRC);

    arb_state_t         state;
    axis_beat_t         out_q;
    logic               out_vld;

    logic [NUM_SRC-1:0] req;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;

    axis_beat_t         sel_beat;
    logic               sel_vld;
    logic               out_rdy;
    logic               beat_acc;

    // Disabled sources are masked only at arbitration time; a grant in
    // progress runs to tlast regardless of src_en.
    assign req = s_tvalid & src_en;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .last    (cur_grant),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    // Mux the granted source's beat onto the output register input.
    always_comb begin
        sel_beat = '0;
        sel_vld  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_grant == IDX_W'(i)) begin
                sel_vld       = s_tvalid[i];
                sel_beat.data = s_tdata[i*AXIS_DATA_W +: AXIS_DATA_W];
                sel_beat.strb = s_tstrb[i*AXIS_STRB_W +: AXIS_STRB_W];
                sel_beat.keep = s_tkeep[i*AXIS_STRB_W +: AXIS_STRB_W];
                sel_beat.user = s_tuser[i*AXIS_USER_W +: AXIS_USER_W];
                sel_beat.last = s_tlast[i];
            end
        end
    end

    // Output register can take a beat when empty or when its current beat leaves this cycle.
    assign out_rdy  = !out_vld || m_axis_tready;
    assign beat_acc = (state == ST_BUSY) && sel_vld && out_rdy;

    always_comb begin
        s_tready = '0;
        if (state == ST_BUSY) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cur_grant == IDX_W'(i)) begin
                    s_tready[i] = out_rdy;
                end
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cur_grant <= IDX_W'(NUM_SRC - 1);
            out_vld   <= 1'b0;
            out_q     <= '0;
            pkt_cnt   <= '0;
        end else begin
            if (out_vld && m_axis_tready && out_q.last) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end

            if (beat_acc) begin
                out_vld <= 1'b1;
                out_q   <= sel_beat;
            end else if (m_axis_tready) begin
                out_vld <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        cur_grant <= pick_idx;
                        state     <= ST_BUSY;
                        busy      <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (beat_acc && sel_beat.last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tstrb  = out_q.strb;
    assign m_axis_tkeep  = out_q.keep;
    assign m_axis_tuser  = out_q.user;
    assign m_axis_tlast  = out_q.last;

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Directed bench for axis_tx_arbiter: queued source packets, master capture, per-scenario checks.
// Latency: n/a.
// Backpressure: master ready pattern selected per scenario.
module tb_axis_tx_arbiter;
    import axis_arb_pkg::*;

    localparam int N = 3;

    logic                 axi_aclk = 1'b0;
    logic                 axi_reset;
    logic [N-1:0]         src_en;
    logic [N-1:0]         s_tvalid;
    logic [N*32-1:0]      s_tdata;
    logic [N*4-1:0]       s_tstrb;
    logic [N*4-1:0]       s_tkeep;
    logic [N*2-1:0]       s_tuser;
    logic [N-1:0]         s_tlast;
    logic [N-1:0]         s_tready;
    logic                 m_axis_tvalid;
    logic [31:0]          m_axis_tdata;
    logic [3:0]           m_axis_tstrb;
    logic [3:0]           m_axis_tkeep;
    logic [1:0]           m_axis_tuser;
    logic                 m_axis_tlast;
    logic                 m_axis_tready;
    logic                 busy;
    logic [1:0]           cur_grant;
    logic [15:0]          pkt_cnt;

    always #5 axi_aclk = ~axi_aclk;

    axis_tx_arbiter #(.NUM_SRC(N), .CNT_W(16)) dut (
        .axi_aclk      (axi_aclk),
        .axi_reset     (axi_reset),
        .src_en        (src_en),
        .s_tvalid      (s_tvalid),
        .s_tdata       (s_tdata),
        .s_tstrb       (s_tstrb),
        .s_tkeep       (s_tkeep),
        .s_tuser       (s_tuser),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .cur_grant     (cur_grant),
        .pkt_cnt       (pkt_cnt)
    );

    axis_beat_t srcq[N][$];
    axis_beat_t got[$];
    int         hs_src[$];
    int         hs_cyc[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle each cycle, 2: never
    bit prev_stall = 1'b0;
    axis_beat_t prev_beat;
    int stall_err  = 0;
    int stall_seen = 0;
    int onehot_err = 0;
    bit rdy1_seen  = 1'b0;

    function automatic axis_beat_t mk_beat(int src, int pkt, int beat, int nbeats);
        axis_beat_t b;
        b.data = 32'hA000_0000 | (32'(src) << 8) | (32'(pkt) << 4) | 32'(beat);
        b.last = (beat == nbeats - 1);
        b.strb = b.last ? 4'h3 : 4'hF;
        b.keep = b.strb;
        b.user = 2'(src);
        return b;
    endfunction

    task automatic push_pkt(int src, int pkt, int nbeats);
        for (int b = 0; b < nbeats; b++) srcq[src].push_back(mk_beat(src, pkt, b, nbeats));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*32 +: 32]  = srcq[i][0].data;
                s_tstrb[i*4 +: 4]    = srcq[i][0].strb;
                s_tkeep[i*4 +: 4]    = srcq[i][0].keep;
                s_tuser[i*2 +: 2]    = srcq[i][0].user;
                s_tlast[i]           = srcq[i][0].last;
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tlast[i]           = 1'b0;
            end
        end
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = cyc[0];
            default: m_axis_tready = 1'b0;
        endcase
    endtask

    // One clock: observe at negedge, then pop accepted source beats after the edge.
    task automatic cycle();
        logic [N-1:0] pop;
        axis_beat_t   cur;
        @(negedge axi_aclk);
        pop = s_tvalid & s_tready;
        if ($countones(s_tready) > 1) onehot_err++;
        if (s_tready[1]) rdy1_seen = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (pop[i]) begin
                hs_src.push_back(i);
                hs_cyc.push_back(cyc);
            end
        end
        cur = {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
        if (prev_stall && (!m_axis_tvalid || cur !== prev_beat)) stall_err++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        if (prev_stall) stall_seen++;
        prev_beat = cur;
        if (m_axis_tvalid && m_axis_tready) got.push_back(cur);
        @(posedge axi_aclk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (pop[i]) void'(srcq[i].pop_front());
        drive();
    endtask

    task automatic test_reset();
        axi_reset = 1'b1;
        src_en    = 3'b111;
        s_tvalid  = '0;
        s_tdata   = '0;
        s_tstrb   = '0;
        s_tkeep   = '0;
        s_tuser   = '0;
        s_tlast   = '0;
        ready_mode = 0;
        drive();
        repeat (3) cycle();
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
        n_checks++; if (m_axis_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
        n_checks++; if (s_tready !== 3'b000) begin n_fail++; $display("FAIL reset_s_tready got=%b exp=000", s_tready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (cur_grant !== 2'd2) begin n_fail++; $display("FAIL reset_cur_grant got=%0d exp=2", cur_grant); end
        n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
    endtask

    task automatic test_round_robin();
        int t;
        axis_beat_t e;
        axi_reset = 1'b0;
        got.delete();
        for (int s = 0; s < N; s++) push_pkt(s, 0, 4);
        drive();
        t = 0;
        while (got.size() < 12 && t < 200) begin cycle(); t++; end
        repeat (3) cycle();
        n_checks++; if (got.size() != 12) begin n_fail++; $display("FAIL rr_beat_count got=%0d exp=12", got.size()); end
        for (int k = 0; k < 12; k++) begin
            e = mk_beat(k / 4, 0, k % 4, 4);
            n_checks++;
            if (k >= got.size() || got[k] !== e) begin
                n_fail++;
                $display("FAIL rr_beat%0d got=%h exp=%h", k, (k < got.size()) ? got[k] : '0, e);
            end
        end
        n_checks++; if (pkt_cnt !== 16'd3) begin n_fail++; $display("FAIL rr_pkt_cnt got=%0d exp=3", pkt_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy_after got=%b exp=0", busy); end
        n_checks++; if (onehot_err != 0) begin n_fail++; $display("FAIL rr_ready_onehot got=%0d violations exp=0", onehot_err); end
    endtask

    task automatic test_single_source();
        int t;
        got.delete(); hs_src.delete(); hs_cyc.delete();
        push_pkt(1, 1, 2);
        push_pkt(1, 2, 2);
        drive();
        t = 0;
        while (got.size() < 4 && t < 200) begin cycle(); t++; end
        repeat (3) cycle();
        n_checks++;
        if (hs_cyc.size() != 4) begin
            n_fail++; $display("FAIL single_hs_count got=%0d exp=4", hs_cyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (hs_src[k] != 1) begin n_fail++; $display("FAIL single_hs_src%0d got=%0d exp=1", k, hs_src[k]); end
            end
            n_checks++; if (hs_cyc[1] - hs_cyc[0] != 1) begin n_fail++; $display("FAIL single_gap01 got=%0d exp=1", hs_cyc[1] - hs_cyc[0]); end
            n_checks++; if (hs_cyc[2] - hs_cyc[1] != 2) begin n_fail++; $display("FAIL single_gap12 got=%0d exp=2", hs_cyc[2] - hs_cyc[1]); end
            n_checks++; if (hs_cyc[3] - hs_cyc[2] != 1) begin n_fail++; $display("FAIL single_gap23 got=%0d exp=1", hs_cyc[3] - hs_cyc[2]); end
        end
        n_checks++; if (cur_grant !== 2'd1) begin n_fail++; $display("FAIL single_cur_grant got=%0d exp=1", cur_grant); end
        n_checks++; if (pkt_cnt !== 16'd5) begin n_fail++; $display("FAIL single_pkt_cnt got=%0d exp=5", pkt_cnt); end
    endtask

    task automatic test_stall();
        int t;
        axis_beat_t e;
        got.delete();
        stall_err = 0; stall_seen = 0;
        ready_mode = 1;
        push_pkt(0, 2, 8);
        drive();
        t = 0;
        while (got.size() < 8 && t < 200) begin cycle(); t++; end
        repeat (4) cycle();
        n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL stall_beat_count got=%0d exp=8", got.size()); end
        for (int k = 0; k < 8; k++) begin
            e = mk_beat(0, 2, k, 8);
            n_checks++;
            if (k >= got.size() || got[k] !== e) begin
                n_fail++;
                $display("FAIL stall_beat%0d got=%h exp=%h", k, (k < got.size()) ? got[k] : '0, e);
            end
        end
        n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_payload_stable got=%0d changes exp=0", stall_err); end
        n_checks++; if (stall_seen == 0) begin n_fail++; $display("FAIL stall_occurred got=0 stalled cycles exp>0"); end
        n_checks++; if (pkt_cnt !== 16'd6) begin n_fail++; $display("FAIL stall_pkt_cnt got=%0d exp=6", pkt_cnt); end
        ready_mode = 0;
        drive();
    endtask

    task automatic test_src_en_mask();
        int t;
        axis_beat_t e;
        got.delete();
        src_en = 3'b101;
        rdy1_seen = 1'b0;
        push_pkt(0, 3, 2);
        push_pkt(1, 3, 2);
        push_pkt(2, 3, 2);
        drive();
        t = 0;
        while (got.size() < 4 && t < 200) begin cycle(); t++; end
        repeat (6) cycle();
        n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL mask_beat_count got=%0d exp=4", got.size()); end
        for (int k = 0; k < 4; k++) begin
            e = mk_beat((k < 2) ? 2 : 0, 3, k % 2, 2);
            n_checks++;
            if (k >= got.size() || got[k] !== e) begin
                n_fail++;
                $display("FAIL mask_beat%0d got=%h exp=%h", k, (k < got.size()) ? got[k] : '0, e);
            end
        end
        n_checks++; if (rdy1_seen) begin n_fail++; $display("FAIL mask_s_tready1 got=1 at some cycle exp=0 always"); end
        n_checks++; if (srcq[1].size() != 2) begin n_fail++; $display("FAIL mask_src1_pending got=%0d exp=2", srcq[1].size()); end
        n_checks++; if (pkt_cnt !== 16'd8) begin n_fail++; $display("FAIL mask_pkt_cnt got=%0d exp=8", pkt_cnt); end
        srcq[1].delete();
        src_en = 3'b111;
        drive();
    endtask

    task automatic test_en_drop();
        int t;
        bit masked;
        axis_beat_t e;
        got.delete(); hs_src.delete(); hs_cyc.delete();
        masked = 1'b0;
        push_pkt(0, 4, 5);
        push_pkt(0, 5, 1);
        drive();
        t = 0;
        while (got.size() < 6 && t < 200) begin
            cycle(); t++;
            if (!masked && hs_src.size() >= 2) begin
                src_en = 3'b110;
                push_pkt(2, 4, 1);
                drive();
                masked = 1'b1;
            end
        end
        repeat (6) cycle();
        n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL endrop_beat_count got=%0d exp=6", got.size()); end
        for (int k = 0; k < 6; k++) begin
            e = (k < 5) ? mk_beat(0, 4, k, 5) : mk_beat(2, 4, 0, 1);
            n_checks++;
            if (k >= got.size() || got[k] !== e) begin
                n_fail++;
                $display("FAIL endrop_beat%0d got=%h exp=%h", k, (k < got.size()) ? got[k] : '0, e);
            end
        end
        n_checks++; if (cur_grant !== 2'd2) begin n_fail++; $display("FAIL endrop_cur_grant got=%0d exp=2", cur_grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL endrop_idle_masked got=%b exp=0", busy); end
        src_en = 3'b111;
        t = 0;
        while (got.size() < 7 && t < 100) begin cycle(); t++; end
        repeat (3) cycle();
        e = mk_beat(0, 5, 0, 1);
        n_checks++;
        if (got.size() < 7 || got[6] !== e) begin
            n_fail++; $display("FAIL endrop_reenabled got=%0d beats exp=7 ending %h", got.size(), e);
        end
        n_checks++; if (pkt_cnt !== 16'd11) begin n_fail++; $display("FAIL endrop_pkt_cnt got=%0d exp=11", pkt_cnt); end
    endtask

    task automatic test_reset_mid_packet();
        int t;
        axis_beat_t e;
        got.delete(); hs_src.delete(); hs_cyc.delete();
        push_pkt(1, 6, 6);
        drive();
        t = 0;
        while (hs_src.size() < 3 && t < 100) begin cycle(); t++; end
        n_checks++; if (hs_src.size() < 3) begin n_fail++; $display("FAIL rstmid_reach_beat3 got=%0d beats exp=3", hs_src.size()); end
        axi_reset = 1'b1;
        srcq[1].delete();
        drive();
        @(posedge axi_aclk);
        #1;
        prev_stall = 1'b0;
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid got=%b exp=0", m_axis_tvalid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_pkt_cnt got=%0d exp=0", pkt_cnt); end
        n_checks++; if (cur_grant !== 2'd2) begin n_fail++; $display("FAIL rstmid_cur_grant got=%0d exp=2", cur_grant); end
        n_checks++; if (s_tready !== 3'b000) begin n_fail++; $display("FAIL rstmid_s_tready got=%b exp=000", s_tready); end
        axi_reset = 1'b0;
        got.delete();
        push_pkt(0, 7, 1);
        push_pkt(1, 7, 1);
        drive();
        t = 0;
        while (got.size() < 2 && t < 100) begin cycle(); t++; end
        for (int k = 0; k < 2; k++) begin
            e = mk_beat(k, 7, 0, 1);
            n_checks++;
            if (k >= got.size() || got[k] !== e) begin
                n_fail++;
                $display("FAIL rstmid_after%0d got=%h exp=%h", k, (k < got.size()) ? got[k] : '0, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_source();
        test_stall();
        test_src_en_mask();
        test_en_drop();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
